operand_fetch_stage: RTL and testbench
======================================

# operand_fetch_stage

Decode-to-execute stage wrapped around the 32×32 register file read ports. It takes a decoded instruction from the decode stage and drives the register file read addresses. It resolves RAW hazards by forwarding from EX, MEM and WB, inserts a one-cycle bubble on load-use, and registers the resolved operands into the ID/EX pipeline register toward the ALU through a valid/ready handshake.

## Interface
- DATA_W, 32, operand/data width
- ADDR_W, 5, register index width (32 registers, R0 hardwired zero)
- CNT_W, 16, width of the load-use stall counter

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  decode presents an instruction
- IN_READY  out  1  stage accepts it this cycle
- IN_RA, IN_RB, IN_RD  in  ADDR_W  source A, source B, destination
- IN_IMM  in  DATA_W  sign-extended immediate
- IN_USE_IMM  in  1  operand B = IMM; RB is then store data only
- IN_OP  in  4  ALU opcode, passed through
- IN_REG_WE, IN_IS_LOAD, IN_IS_STORE  in  1  control, passed through
- RA, RB  out  ADDR_W  register file read addresses (combinational = IN_RA/IN_RB)
- PA, PB  in  DATA_W  register file read data
- EX_RESULT  in  DATA_W  ALU result of the instruction held in this stage's output register
- MEM_RD  in  ADDR_W; MEM_WE  in  1; MEM_DATA  in  DATA_W  MEM-stage writer
- WB_RD  in  ADDR_W; WB_WE  in  1; WB_DATA  in  DATA_W  same signals as register file RW/LE/PW
- FLUSH  in  1  synchronous squash (branch taken)
- OUT_VALID  out  1; OUT_READY  in  1  downstream handshake
- OUT_A, OUT_B, OUT_SD  out  DATA_W  operand A, operand B, store data
- OUT_RD  out  ADDR_W; OUT_OP  out  4; OUT_REG_WE, OUT_IS_LOAD, OUT_IS_STORE  out  1
- STALL_CNT  out  CNT_W  saturating count of load-use bubbles

## Operation
- Forward per source S (RA, RB). Priority is first match:
  - S==0 → 0.
  - EX: OUT_VALID && OUT_REG_WE && !OUT_IS_LOAD && OUT_RD==S → EX_RESULT.
  - MEM: MEM_WE && MEM_RD==S → MEM_DATA.
  - WB: WB_WE && WB_RD==S → WB_DATA.
  - Otherwise → PA/PB.
- Operand assignment:
  - OUT_A ← fwdA.
  - OUT_B ← IN_USE_IMM ? IN_IMM : fwdB.
  - OUT_SD ← fwdB.
- Load-use hazard: OUT_VALID && OUT_IS_LOAD && OUT_RD!=0, and OUT_RD equals IN_RA or IN_RB. This check applies to RB even when IN_USE_IMM, because RB may be store data. The rule is deliberately conservative.
- States of the output register:
  - EMPTY (OUT_VALID=0) → FULL on accept.
  - FULL → FULL on accept while OUT_READY.
  - FULL → EMPTY on OUT_READY with no accept, or on FLUSH.
  - FULL holds contents while !OUT_READY.
- Hazard bubble: when the hazard is true and OUT_READY=1, the load leaves and OUT_VALID goes 0 next cycle. The decode instruction is not accepted.
- IN_READY = (!OUT_VALID || OUT_READY) && !hazard && !FLUSH.
- FLUSH: OUT_VALID ← 0 next edge and the input is not accepted that cycle. FLUSH wins over every other event.
- STALL_CNT increments by 1 on each cycle where IN_VALID && hazard && !FLUSH. It saturates at all-ones and is cleared only by reset.

## Timing
- Latency is 1 cycle from accept (IN_VALID && IN_READY at edge N) to OUT_* valid after edge N.
- Handshake:
  - OUT_* stay stable while OUT_VALID && !OUT_READY.
  - Decode must hold IN_* stable while IN_VALID && !IN_READY.
- IN_READY, RA and RB are combinational. OUT_* and STALL_CNT are registered.
- Reset (RST_N low, asynchronous assert) drives OUT_VALID, all OUT_* fields and STALL_CNT to 0. Release is synchronised externally.
- Reset mid-transfer drops the held instruction; no partial state survives.
- A WB write and a read of the same register in one cycle return WB_DATA through the bypass, not the stale PA/PB.

## Structure
- Shared package `pf1_pkg` holds DATA_W, ADDR_W, the ZERO_REG constant, and the opcode enum for IN_OP/OUT_OP.
- One sub-module, `fwd_mux`, instantiated twice, one per source. Its inputs are src, EX/MEM/WB fields and rf_data; its output is the forwarded value.
- The handshake, hazard detection and counter live in the top level.

## Test plan
- Write R3=20 via WB, issue ADD RA=3 RB=0 with WB_WE still asserted for R3 → OUT_A=20, OUT_B=0 one cycle later.
- Back-to-back: ADD R5←EX_RESULT=7, next instruction reads R5; MEM also writes R5=9 → OUT_A=7 (EX priority).
- LOAD R4, then SUB RA=4 → IN_READY=0 for 1 cycle, one bubble (OUT_VALID=0), STALL_CNT=1. Next cycle MEM_DATA=0x55 is forwarded to OUT_A.
- Hold OUT_READY=0 for 3 cycles with IN_VALID=1 → OUT_* unchanged, IN_READY=0, no instruction lost after release.
- FLUSH asserted while FULL and IN_VALID=1 → OUT_VALID=0 next cycle, input not consumed, STALL_CNT unchanged.
- Source R0 with MEM_WE=1, MEM_RD=0, MEM_DATA=0xFFFF → OUT_A=0. Async RST_N low mid-stream → OUT_VALID=0 and STALL_CNT=0 immediately.

Source files
------------

// File: rtl/pf1_pkg.sv
// Shared definitions for the operand fetch stage.
//   DATA_W / ADDR_W : default operand and register-index widths
//   ZERO_REG        : index of the hardwired-zero register
//   op_e            : ALU opcode carried on IN_OP/OUT_OP
//   occ_e           : occupancy of the ID/EX output register
package pf1_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_LUI  = 4'd10
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } occ_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-source bypass selector.
//   src_i      : register index being read
//   ex_en_i    : EX stage holds a forwardable (non-load) register write
//   ex_rd_i/ex_data_i, mem_*, wb_* : writer destinations and data
//   rf_data_i  : register file read data for src_i
//   fwd_o      : resolved operand (R0 > EX > MEM > WB > register file)
module fwd_mux
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic              ex_en_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] fwd_o
);

  import pf1_pkg::*;

  always_comb begin
    fwd_o = rf_data_i;
    if (src_i == ADDR_W'(ZERO_REG)) begin
      fwd_o = '0;
    end else if (ex_en_i && (ex_rd_i == src_i)) begin
      fwd_o = ex_data_i;
    end else if (mem_we_i && (mem_rd_i == src_i)) begin
      fwd_o = mem_data_i;
    end else if (wb_we_i && (wb_rd_i == src_i)) begin
      fwd_o = wb_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch stage.
//   CLK/RST_N                  : clock, async active-low reset
//   IN_*                       : decoded instruction with valid/ready handshake
//   RA/RB, PA/PB               : register file read address / data
//   EX_RESULT, MEM_*, WB_*     : bypass sources
//   FLUSH                      : squash the output register, refuse input
//   OUT_*                      : ID/EX register toward the ALU, valid/ready
//   STALL_CNT                  : saturating count of load-use stall cycles
module operand_fetch_stage
#(
  parameter int unsigned DATA_W = pf1_pkg::DATA_W,
  parameter int unsigned ADDR_W = pf1_pkg::ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_RA,
  input  logic [ADDR_W-1:0] IN_RB,
  input  logic [ADDR_W-1:0] IN_RD,
  input  logic [DATA_W-1:0] IN_IMM,
  input  logic              IN_USE_IMM,
  input  logic [3:0]        IN_OP,
  input  logic              IN_REG_WE,
  input  logic              IN_IS_LOAD,
  input  logic              IN_IS_STORE,
  output logic [ADDR_W-1:0] RA,
  output logic [ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0] PA,
  input  logic [DATA_W-1:0] PB,
  input  logic [DATA_W-1:0] EX_RESULT,
  input  logic [ADDR_W-1:0] MEM_RD,
  input  logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_DATA,
  input  logic [ADDR_W-1:0] WB_RD,
  input  logic              WB_WE,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_A,
  output logic [DATA_W-1:0] OUT_B,
  output logic [DATA_W-1:0] OUT_SD,
  output logic [ADDR_W-1:0] OUT_RD,
  output logic [3:0]        OUT_OP,
  output logic              OUT_REG_WE,
  output logic              OUT_IS_LOAD,
  output logic              OUT_IS_STORE,
  output logic [CNT_W-1:0]  STALL_CNT
);

  import pf1_pkg::*;

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, sd_q;
  logic [ADDR_W-1:0] rd_q;
  op_e               op_q;
  logic              we_q, ld_q, st_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_valid;
  logic              ex_en;
  logic              hazard;
  logic              accept;
  logic              load_en;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  assign RA        = IN_RA;
  assign RB        = IN_RB;
  assign out_valid = (state_q == ST_FULL);

  // A load's EX_RESULT is only an address, so loads never forward from EX.
  assign ex_en = out_valid && we_q && !ld_q;

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .src_i      (IN_RA),
    .ex_en_i    (ex_en),
    .ex_rd_i    (rd_q),
    .ex_data_i  (EX_RESULT),
    .mem_we_i   (MEM_WE),
    .mem_rd_i   (MEM_RD),
    .mem_data_i (MEM_DATA),
    .wb_we_i    (WB_WE),
    .wb_rd_i    (WB_RD),
    .wb_data_i  (WB_DATA),
    .rf_data_i  (PA),
    .fwd_o      (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .src_i      (IN_RB),
    .ex_en_i    (ex_en),
    .ex_rd_i    (rd_q),
    .ex_data_i  (EX_RESULT),
    .mem_we_i   (MEM_WE),
    .mem_rd_i   (MEM_RD),
    .mem_data_i (MEM_DATA),
    .wb_we_i    (WB_WE),
    .wb_rd_i    (WB_RD),
    .wb_data_i  (WB_DATA),
    .rf_data_i  (PB),
    .fwd_o      (fwd_b)
  );

  // RB is checked even with an immediate operand: it may carry store data.
  always_comb begin
    hazard = out_valid && ld_q && (rd_q != ADDR_W'(ZERO_REG)) &&
             ((rd_q == IN_RA) || (rd_q == IN_RB));
  end

  assign IN_READY = (!out_valid || OUT_READY) && !hazard && !FLUSH;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            load_en = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept) begin
            load_en = 1'b1;
          end else if (OUT_READY) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (IN_VALID && hazard && !FLUSH && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q  <= '0;
      b_q  <= '0;
      sd_q <= '0;
      rd_q <= '0;
      op_q <= OP_ADD;
      we_q <= 1'b0;
      ld_q <= 1'b0;
      st_q <= 1'b0;
    end else if (load_en) begin
      a_q  <= fwd_a;
      b_q  <= IN_USE_IMM ? IN_IMM : fwd_b;
      sd_q <= fwd_b;
      rd_q <= IN_RD;
      op_q <= op_e'(IN_OP);
      we_q <= IN_REG_WE;
      ld_q <= IN_IS_LOAD;
      st_q <= IN_IS_STORE;
    end
  end

  assign OUT_VALID    = out_valid;
  assign OUT_A        = a_q;
  assign OUT_B        = b_q;
  assign OUT_SD       = sd_q;
  assign OUT_RD       = rd_q;
  assign OUT_OP       = op_q;
  assign OUT_REG_WE   = we_q;
  assign OUT_IS_LOAD  = ld_q;
  assign OUT_IS_STORE = st_q;
  assign STALL_CNT    = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  import pf1_pkg::*;

  logic        CLK, RST_N;
  logic        IN_VALID, IN_READY;
  logic [4:0]  IN_RA, IN_RB, IN_RD;
  logic [31:0] IN_IMM;
  logic        IN_USE_IMM;
  logic [3:0]  IN_OP;
  logic        IN_REG_WE, IN_IS_LOAD, IN_IS_STORE;
  logic [4:0]  RA, RB;
  logic [31:0] PA, PB, EX_RESULT;
  logic [4:0]  MEM_RD, WB_RD;
  logic        MEM_WE, WB_WE;
  logic [31:0] MEM_DATA, WB_DATA;
  logic        FLUSH;
  logic        OUT_VALID, OUT_READY;
  logic [31:0] OUT_A, OUT_B, OUT_SD;
  logic [4:0]  OUT_RD;
  logic [3:0]  OUT_OP;
  logic        OUT_REG_WE, OUT_IS_LOAD, OUT_IS_STORE;
  logic [15:0] STALL_CNT;

  operand_fetch_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_RA(IN_RA), .IN_RB(IN_RB), .IN_RD(IN_RD),
    .IN_IMM(IN_IMM), .IN_USE_IMM(IN_USE_IMM), .IN_OP(IN_OP),
    .IN_REG_WE(IN_REG_WE), .IN_IS_LOAD(IN_IS_LOAD), .IN_IS_STORE(IN_IS_STORE),
    .RA(RA), .RB(RB), .PA(PA), .PB(PB),
    .EX_RESULT(EX_RESULT),
    .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .MEM_DATA(MEM_DATA),
    .WB_RD(WB_RD), .WB_WE(WB_WE), .WB_DATA(WB_DATA),
    .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_SD(OUT_SD),
    .OUT_RD(OUT_RD), .OUT_OP(OUT_OP),
    .OUT_REG_WE(OUT_REG_WE), .OUT_IS_LOAD(OUT_IS_LOAD), .OUT_IS_STORE(OUT_IS_STORE),
    .STALL_CNT(STALL_CNT)
  );

  typedef struct {
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        we, ld, st;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic [31:0] imm, input logic use_imm, input logic [3:0] op,
                        input logic we, input logic ld, input logic st);
    IN_RA = ra; IN_RB = rb; IN_RD = rd; IN_IMM = imm; IN_USE_IMM = use_imm;
    IN_OP = op; IN_REG_WE = we; IN_IS_LOAD = ld; IN_IS_STORE = st;
    IN_VALID = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    exp_t e;
    e.a = a; e.b = b; e.sd = sd;
    e.rd = IN_RD; e.op = IN_OP; e.we = IN_REG_WE; e.ld = IN_IS_LOAD; e.st = IN_IS_STORE;
    sb.push_back(e);
  endtask

  // Monitor: every downstream transfer must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST_N && OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: got rd=%0d a=0x%0h expected no transfer", OUT_RD, OUT_A);
        end else begin
          e = sb.pop_front();
          chk("out_a",  OUT_A,  e.a);
          chk("out_b",  OUT_B,  e.b);
          chk("out_sd", OUT_SD, e.sd);
          chk("out_ctl", {OUT_RD, OUT_OP, OUT_REG_WE, OUT_IS_LOAD, OUT_IS_STORE},
                         {e.rd, e.op, e.we, e.ld, e.st});
        end
      end
    end
  end

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0;
    IN_RA = '0; IN_RB = '0; IN_RD = '0; IN_IMM = '0; IN_USE_IMM = 1'b0;
    IN_OP = '0; IN_REG_WE = 1'b0; IN_IS_LOAD = 1'b0; IN_IS_STORE = 1'b0;
    PA = '0; PB = '0; EX_RESULT = '0;
    MEM_RD = '0; MEM_WE = 1'b0; MEM_DATA = '0;
    WB_RD = '0; WB_WE = 1'b0; WB_DATA = '0;
    FLUSH = 1'b0; OUT_READY = 1'b1;

    #1;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_cnt",   STALL_CNT, 0);
    chk("rst_out_a", OUT_A, 0);
    step(); step();
    RST_N = 1'b1;

    // WB write of R3 bypassed to a same-cycle read
    WB_WE = 1'b1; WB_RD = 5'd3; WB_DATA = 32'd20; PA = 32'h1111; PB = 32'h2222;
    set_in(5'd3, 5'd0, 5'd6, 32'd0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("wb_ready", IN_READY, 1);
    chk("rf_addr_a", RA, 3);
    push(32'd20, 32'd0, 32'd0);
    step();
    IN_VALID = 1'b0; WB_WE = 1'b0;

    // Back-to-back: EX beats MEM for R5
    PA = 32'h10; PB = 32'h20;
    set_in(5'd1, 5'd2, 5'd5, 32'd0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("b2b1_ready", IN_READY, 1);
    push(32'h10, 32'h20, 32'h20);
    step();
    EX_RESULT = 32'd7; MEM_WE = 1'b1; MEM_RD = 5'd5; MEM_DATA = 32'd9;
    PA = 32'h33; PB = 32'h44;
    set_in(5'd5, 5'd0, 5'd7, 32'd0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("b2b2_ready", IN_READY, 1);
    push(32'd7, 32'd0, 32'd0);
    step();
    IN_VALID = 1'b0; MEM_WE = 1'b0; EX_RESULT = 32'hDEAD;

    // Load-use: LOAD R4 then SUB RA=4
    PA = 32'h100;
    set_in(5'd1, 5'd0, 5'd4, 32'd8, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("ld_ready", IN_READY, 1);
    push(32'h100, 32'd8, 32'd0);
    step();
    PA = 32'hBAD; PB = 32'h22;
    set_in(5'd4, 5'd2, 5'd8, 32'd0, 1'b0, OP_SUB, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("lu_ready", IN_READY, 0);
    chk("lu_cnt_before", STALL_CNT, 0);
    step();
    MEM_WE = 1'b1; MEM_RD = 5'd4; MEM_DATA = 32'h55;
    @(negedge CLK);
    chk("lu_bubble", OUT_VALID, 0);
    chk("lu_cnt", STALL_CNT, 1);
    chk("lu_ready_after", IN_READY, 1);
    push(32'h55, 32'h22, 32'h22);
    step();
    IN_VALID = 1'b0; MEM_WE = 1'b0;

    // Backpressure for 3 cycles with a pending instruction (a load to R9)
    OUT_READY = 1'b0;
    set_in(5'd0, 5'd0, 5'd9, 32'h40, 1'b1, OP_ADD, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_ready", IN_READY, 0);
      chk("bp_valid", OUT_VALID, 1);
      chk("bp_hold_a", OUT_A, 32'h55);
      chk("bp_hold_rd", OUT_RD, 8);
      step();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_ready", IN_READY, 1);
    push(32'd0, 32'h40, 32'd0);
    step();

    // FLUSH while FULL with a would-be load-use hazard pending
    FLUSH = 1'b1; PA = 32'h99; PB = 32'h22;
    set_in(5'd9, 5'd2, 5'd11, 32'd0, 1'b0, OP_XOR, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("fl_ready", IN_READY, 0);
    step();
    FLUSH = 1'b0;
    @(negedge CLK);
    chk("fl_valid", OUT_VALID, 0);
    chk("fl_cnt", STALL_CNT, 1);
    chk("fl_ready_after", IN_READY, 1);
    push(32'h99, 32'h22, 32'h22);
    step();

    // R0 source ignores a MEM write to R0
    MEM_WE = 1'b1; MEM_RD = 5'd0; MEM_DATA = 32'hFFFF; PA = 32'h1234; PB = 32'h33;
    set_in(5'd0, 5'd3, 5'd10, 32'd0, 1'b0, OP_OR, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("r0_ready", IN_READY, 1);
    push(32'd0, 32'h33, 32'h33);
    step();
    IN_VALID = 1'b0; MEM_WE = 1'b0;
    @(negedge CLK);
    step();

    // MEM beats WB; then async reset drops the held instruction
    MEM_WE = 1'b1; MEM_RD = 5'd6; MEM_DATA = 32'h66;
    WB_WE = 1'b1; WB_RD = 5'd6; WB_DATA = 32'h77; PA = 32'h1; PB = 32'h1;
    set_in(5'd6, 5'd6, 5'd12, 32'd0, 1'b0, OP_AND, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("mw_ready", IN_READY, 1);
    push(32'h66, 32'h66, 32'h66);
    step();
    IN_VALID = 1'b0; MEM_WE = 1'b0; WB_WE = 1'b0; OUT_READY = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst2_valid", OUT_VALID, 0);
    chk("rst2_cnt", STALL_CNT, 0);
    chk("rst2_out_a", OUT_A, 0);
    chk("rst2_out_rd", OUT_RD, 0);
    if (sb.size() > 0) void'(sb.pop_back());
    step();
    RST_N = 1'b1; OUT_READY = 1'b1;

    // Clean instruction after reset
    PA = 32'h5A; PB = 32'h5B;
    set_in(5'd1, 5'd2, 5'd13, 32'd0, 1'b0, OP_ADD, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    chk("post_rst_ready", IN_READY, 1);
    push(32'h5A, 32'h5B, 32'h5B);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    step();
    @(negedge CLK);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
